// File: rtl/mpc_vec_addsub_sat.sv
// Vector add/sub with signed saturation over two read ports and one write port.
// Ports: ap_* block handshake, mode/len config, a/b read ports, y write port, sat_cnt.
module mpc_vec_addsub_sat #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  output logic          ap_idle,
  output logic          ap_ready,
  input  logic [1:0]    mode,
  input  logic [AW:0]   len,
  output logic [AW-1:0] a_address0,
  output logic          a_ce0,
  input  logic [DW-1:0] a_q0,
  output logic [AW-1:0] b_address0,
  output logic          b_ce0,
  input  logic [DW-1:0] b_q0,
  output logic [AW-1:0] y_address0,
  output logic          y_ce0,
  output logic          y_we0,
  output logic [DW-1:0] y_d0,
  output logic [AW:0]   sat_cnt
);

  if (DW < 2 || AW < 1) begin : g_bad_cfg
    $error("mpc_vec_addsub_sat: need DW>=2 and AW>=1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW:0]   LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ONE_S   = (AW + 1)'(1);
  localparam logic [DW-1:0] Y_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN   = {1'b1, {(DW-1){1'b0}}};

  state_t state;
  state_t state_nxt;

  logic [1:0]    mode_q;
  logic [AW-1:0] last_q;
  logic          zero_q;
  logic [AW-1:0] idx;
  logic          wr_vld;
  logic [AW-1:0] wr_addr;

  logic [AW:0]   len_c;
  logic          len_zero;
  logic          start_ok;
  logic          rd_en;
  logic          rd_last;

  logic signed [DW:0] a_x;
  logic signed [DW:0] b_x;
  logic signed [DW:0] sum;
  logic               ovf;
  logic [DW-1:0]      res;

  // Oversized lengths collapse to a full memory sweep.
  assign len_c    = (len > LEN_MAX) ? LEN_MAX : len;
  assign len_zero = (len == '0);
  assign start_ok = (state == S_IDLE) && ap_start;
  assign rd_en    = (state == S_RUN);
  assign rd_last  = rd_en && (idx == last_q);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nxt = len_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (idx == last_q) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle    = (state == S_IDLE);
    ap_done    = (state == S_DONE);
    // An empty run has no last read, so ready rides on done.
    ap_ready   = rd_last || ((state == S_DONE) && zero_q);
    a_ce0      = rd_en;
    b_ce0      = rd_en;
    a_address0 = rd_en ? idx : '0;
    b_address0 = rd_en ? idx : '0;
    y_ce0      = wr_vld;
    y_we0      = wr_vld;
    y_address0 = wr_vld ? wr_addr : '0;
    y_d0       = wr_vld ? res : '0;
  end

  assign a_x = {a_q0[DW-1], a_q0};
  assign b_x = {b_q0[DW-1], b_q0};

  always_comb begin
    sum = '0;
    unique case (mode_q)
      2'b00:   sum = a_x + b_x;
      2'b01:   sum = a_x - b_x;
      2'b10:   sum = b_x - a_x;
      2'b11:   sum = a_x + b_x;
      default: sum = a_x + b_x;
    endcase
  end

  // Top two bits of the widened result disagree only on overflow.
  assign ovf = (mode_q != 2'b11) && (sum[DW] != sum[DW-1]);

  always_comb begin
    res = sum[DW-1:0];
    if (ovf) begin
      res = sum[DW] ? Y_MIN : Y_MAX;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      mode_q  <= '0;
      last_q  <= '0;
      zero_q  <= 1'b0;
      idx     <= '0;
      wr_vld  <= 1'b0;
      wr_addr <= '0;
      sat_cnt <= '0;
    end else begin
      wr_vld  <= rd_en;
      wr_addr <= idx;
      if (start_ok) begin
        mode_q  <= mode;
        last_q  <= len_c[AW-1:0] - ONE_A;
        zero_q  <= len_zero;
        idx     <= '0;
        sat_cnt <= '0;
      end else begin
        // Index parks on the last address instead of wrapping.
        if (rd_en && !rd_last) begin
          idx <= idx + ONE_A;
        end
        if (wr_vld && ovf) begin
          sat_cnt <= sat_cnt + ONE_S;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpc_vec_addsub_sat.sv
// Randomized self-checking bench for mpc_vec_addsub_sat.
// Memories and a plain-arithmetic reference model live here.
module tb_mpc_vec_addsub_sat;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          ap_clk;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          ap_ready;
  logic [1:0]    mode;
  logic [AW:0]   len;
  logic [AW-1:0] a_address0;
  logic          a_ce0;
  logic [DW-1:0] a_q0;
  logic [AW-1:0] b_address0;
  logic          b_ce0;
  logic [DW-1:0] b_q0;
  logic [AW-1:0] y_address0;
  logic          y_ce0;
  logic          y_we0;
  logic [DW-1:0] y_d0;
  logic [AW:0]   sat_cnt;

  mpc_vec_addsub_sat #(.DW(DW), .AW(AW)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ap_ready(ap_ready),
    .mode(mode),
    .len(len),
    .a_address0(a_address0),
    .a_ce0(a_ce0),
    .a_q0(a_q0),
    .b_address0(b_address0),
    .b_ce0(b_ce0),
    .b_q0(b_q0),
    .y_address0(y_address0),
    .y_ce0(y_ce0),
    .y_we0(y_we0),
    .y_d0(y_d0),
    .sat_cnt(sat_cnt)
  );

  logic [31:0] a_mem [N];
  logic [31:0] b_mem [N];
  logic [31:0] y_mem [N];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int nrd = 0;
  int nwr = 0;
  int rdy_cnt = 0;
  int rdy_rel = -1;
  int done_cnt = 0;
  int last_wa = -1;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(posedge ap_clk) begin
    if (a_ce0) a_q0 <= a_mem[a_address0];
    if (b_ce0) b_q0 <= b_mem[b_address0];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    int rel;
    #1;
    rel = cyc - t0;
    if (a_ce0) begin
      nrd++;
      chk("rd_cyc", 64'(rel), 64'(nrd));
      chk("rd_addr", 64'(a_address0), 64'(nrd - 1));
      chk("b_port", {b_ce0, b_address0}, {1'b1, a_address0});
    end
    if (y_ce0) begin
      nwr++;
      chk("wr_cyc", 64'(rel), 64'(nwr + 1));
      chk("wr_addr", 64'(y_address0), 64'(nwr - 1));
      chk("wr_we", 64'(y_we0), 64'(1));
      y_mem[y_address0] = y_d0;
      last_wa = int'(y_address0);
    end
    if (ap_idle || ap_done) begin
      chk("quiet", {a_ce0, b_ce0, y_ce0, y_we0}, 64'(0));
    end
    if (ap_ready) begin
      rdy_cnt++;
      rdy_rel = rel;
    end
    if (ap_done) done_cnt++;
  end

  function automatic logic [31:0] ref_op(input logic [1:0] m,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         output bit sat);
    longint sa, sb, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (m)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: r = sb - sa;
      default: r = sa + sb;
    endcase
    sat = 1'b0;
    if (m != 2'd3) begin
      if (r > SMAX) begin
        r = SMAX;
        sat = 1'b1;
      end else if (r < SMIN) begin
        r = SMIN;
        sat = 1'b1;
      end
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h7fffff00 + $urandom_range(0, 255);
      2: return 32'h80000000 + $urandom_range(0, 255);
      default: return $urandom_range(0, 1000) - 500;
    endcase
  endfunction

  task automatic kick(input logic [1:0] m, input int ln,
                      input bit rel_rst);
    @(negedge ap_clk);
    ap_start = 1'b1;
    mode = m;
    len = 6'(ln);
    if (rel_rst) ap_rst = 1'b0;
    t0 = cyc;
    nrd = 0;
    nwr = 0;
    rdy_cnt = 0;
    rdy_rel = -1;
    last_wa = -1;
    for (int i = 0; i < N; i++) y_mem[i] = 'x;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
  endtask

  task automatic wait_done(output int rel);
    rel = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        rel = cyc - t0;
        break;
      end
    end
  endtask

  task automatic do_run(input logic [1:0] m, input int ln,
                        input bit rel_rst);
    logic [31:0] ey [N];
    int leff, esat, rel, edone;
    bit s;
    leff = (ln > N) ? N : ln;
    esat = 0;
    for (int i = 0; i < leff; i++) begin
      ey[i] = ref_op(m, a_mem[i], b_mem[i], s);
      if (s) esat++;
    end
    kick(m, ln, rel_rst);
    wait_done(rel);
    edone = (leff == 0) ? 1 : leff + 2;
    chk("done_cyc", 64'(rel), 64'(edone));
    #2;
    chk("n_reads", 64'(nrd), 64'(leff));
    chk("n_writes", 64'(nwr), 64'(leff));
    chk("ready_cnt", 64'(rdy_cnt), 64'(1));
    chk("ready_cyc", 64'(rdy_rel), 64'((leff == 0) ? 1 : leff));
    chk("sat_cnt", 64'(sat_cnt), 64'(esat));
    if (leff > 0) chk("last_wa", 64'(last_wa), 64'(leff - 1));
    for (int i = 0; i < leff; i++) begin
      chk($sformatf("y[%0d]", i), 64'(y_mem[i]), 64'(ey[i]));
    end
    @(negedge ap_clk);
    chk("idle_after", 64'(ap_idle), 64'(1));
    chk("sat_hold", 64'(sat_cnt), 64'(esat));
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      a_mem[i] = a;
      b_mem[i] = b;
    end
  endtask

  initial begin
    int rel, nwr_at, dc0;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    mode = '0;
    len = '0;
    a_q0 = '0;
    b_q0 = '0;
    for (int i = 0; i < N; i++) y_mem[i] = 'x;

    repeat (2) @(negedge ap_clk);
    chk("rst_idle", 64'(ap_idle), 64'(1));
    chk("rst_done", {ap_done, ap_ready}, 64'(0));
    chk("rst_sat", 64'(sat_cnt), 64'(0));
    chk("rst_y", {y_ce0, y_we0, y_address0, y_d0}, 64'(0));

    // scenario 1: start on first edge out of reset
    for (int i = 0; i < N; i++) begin
      a_mem[i] = i;
      b_mem[i] = 100;
    end
    do_run(2'd0, 24, 1'b1);

    // scenario 2: positive saturation vs wrap
    fill(32'h7ffffff0, 32'h20);
    do_run(2'd0, 2, 1'b0);
    do_run(2'd3, 2, 1'b0);
    chk("wrap_y0", 64'(y_mem[0]), 64'h80000010);

    // scenario 3: subtraction corners
    fill(32'h0, 32'h80000000);
    do_run(2'd1, 1, 1'b0);
    chk("sub_sat", 64'(y_mem[0]), 64'h7fffffff);
    do_run(2'd2, 1, 1'b0);
    chk("rsub_y", 64'(y_mem[0]), 64'h80000000);

    // scenario 4: empty run, full sweep, oversized len
    for (int i = 0; i < N; i++) begin
      a_mem[i] = rnd_val();
      b_mem[i] = rnd_val();
    end
    do_run(2'd0, 0, 1'b0);
    do_run(2'd1, 32, 1'b0);
    do_run(2'd2, 40, 1'b0);
    do_run(2'd0, 63, 1'b0);

    // scenario 5: reset mid-run
    for (int i = 0; i < N; i++) begin
      a_mem[i] = i * 3;
      b_mem[i] = 7;
    end
    dc0 = done_cnt;
    kick(2'd0, 24, 1'b0);
    for (int k = 0; k < 20 && (cyc - t0) != 5; k++) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    chk("abort_ce", {a_ce0, b_ce0, y_ce0, y_we0}, 64'(0));
    chk("abort_addr", {a_address0, b_address0, y_address0}, 64'(0));
    chk("abort_yd", 64'(y_d0), 64'(0));
    chk("abort_sat", 64'(sat_cnt), 64'(0));
    chk("abort_idle", {ap_idle, ap_done, ap_ready}, 64'b100);
    #1;
    nwr_at = nwr;
    chk("abort_wr_before", 64'(nwr_at), 64'(3));
    repeat (3) @(negedge ap_clk);
    #2;
    chk("abort_no_wr", 64'(nwr), 64'(nwr_at));
    chk("abort_no_done", 64'(done_cnt), 64'(dc0));
    do_run(2'd0, 24, 1'b1);

    // scenario 6: start held high through a run
    fill(32'h10, 32'h5);
    @(negedge ap_clk);
    ap_start = 1'b1;
    mode = 2'd0;
    len = 6'd3;
    t0 = cyc;
    nrd = 0;
    nwr = 0;
    wait_done(rel);
    chk("hold_done", 64'(rel), 64'(5));
    #2;
    chk("hold_reads", 64'(nrd), 64'(3));
    @(negedge ap_clk);
    chk("hold_idle", {ap_idle, a_ce0}, 64'b10);
    t0 = cyc;
    nrd = 0;
    nwr = 0;
    @(negedge ap_clk);
    ap_start = 1'b0;
    chk("hold_restart", {ap_idle, a_ce0}, 64'b01);
    wait_done(rel);
    chk("hold_done2", 64'(rel), 64'(5));
    #2;
    chk("hold_y2", 64'(y_mem[2]), 64'h15);
    @(negedge ap_clk);

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i] = rnd_val();
        b_mem[i] = rnd_val();
      end
      do_run(2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mpc_vec_addsub_sat.md
MPC_VEC_ADDSUB_SAT -- requirements
Module: mpc_vec_addsub_sat

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DW, 32, signed element width.
- AW, 5, memory address width.
- REQ-001a: the block SHALL reject at elaboration any configuration with DW<2 or AW<1.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high; ports named ap_clk and ap_rst.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- ap_clk, in, 1, clock.
- ap_rst, in, 1, async active-high reset.
- ap_start, in, 1, start request.
- ap_done, out, 1, one-cycle completion pulse.
- ap_idle, out, 1, high when no operation is in progress.
- ap_ready, out, 1, one-cycle pulse in the cycle the last read is issued.
- mode, in, 2, operation select, sampled at start.
- len, in, AW+1, element count, sampled at start; legal range 0..2^AW.
- a_address0, out, AW, operand A read address.
- a_ce0, out, 1, operand A read enable.
- a_q0, in, DW, operand A data, valid one cycle after a_ce0.
- b_address0, out, AW, operand B read address.
- b_ce0, out, 1, operand B read enable.
- b_q0, in, DW, operand B data, valid one cycle after b_ce0.
- y_address0, out, AW, result write address.
- y_ce0, out, 1, result write enable.
- y_we0, out, 1, result write strobe.
- y_d0, out, DW, result data.
- sat_cnt, out, AW+1, count of saturated elements in the current or last run.

Function
REQ-004 The state machine SHALL have four states, IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN when ap_start=1 and latched len>0.
- IDLE->DONE when ap_start=1 and len=0.
- RUN->DRAIN after the read of index L-1 is issued.
- DRAIN->DONE after the write of index L-1.
- DONE->IDLE unconditionally.
REQ-005 On start acceptance the block SHALL latch mode and len (L), clear the read index to 0 and clear sat_cnt to 0.
REQ-006 In RUN the block SHALL, each cycle:
- assert a_ce0 and b_ce0 with a_address0 = b_address0 = i;
- increment i;
- issue exactly L reads, for indices 0..L-1 in order.
REQ-007 Each write SHALL occur exactly one cycle after its read: y_ce0 = y_we0 = 1 and y_address0 = i registered. The first write SHALL occur in the cycle after the first read.
REQ-008 Results SHALL be computed in DW+1 signed bits, according to mode:
- 00: a+b
- 01: a-b
- 10: b-a
- 11: a+b wrapping (DW LSBs, no saturation)
REQ-009 In modes 00, 01 and 10, any result above 2^(DW-1)-1 SHALL be written as 2^(DW-1)-1 and any result below -2^(DW-1) SHALL be written as -2^(DW-1). Each clamped element SHALL increment sat_cnt by 1.
REQ-010 Mode 11 SHALL never increment sat_cnt.
REQ-011 Timing relative to start acceptance at edge T, for L>0:
- reads are issued in cycles T+1..T+L;
- writes occur in cycles T+2..T+L+1;
- ap_done is high in cycle T+L+2.
REQ-012 For L=0, ap_done SHALL be high in cycle T+1 with no reads, no writes and sat_cnt=0.
REQ-013 ap_ready SHALL pulse high for one cycle in the cycle of the last read (cycle T+L). For L=0 it SHALL pulse together with ap_done.
REQ-014 ap_idle SHALL be 1 only in IDLE. ap_start SHALL be ignored in every state other than IDLE.
REQ-015 len>2^AW SHALL be treated as 2^AW.
REQ-016 The read index SHALL never wrap: index 2^AW-1 is the final legal address.
REQ-017 sat_cnt SHALL hold its value after DONE until the next start is accepted.
REQ-018 All enables and strobes SHALL be 0 in IDLE and in DONE.

Reset
REQ-019 While ap_rst=1, asynchronously:
- the state SHALL be IDLE;
- ap_done, ap_ready, a_ce0, b_ce0, y_ce0 and y_we0 SHALL be 0;
- all addresses, y_d0 and sat_cnt SHALL be 0;
- ap_idle SHALL be 1.
REQ-020 Reset asserted mid-run SHALL abort the operation immediately. No further writes SHALL be issued and ap_done SHALL NOT be asserted for the aborted run.
REQ-021 The first start SHALL be accepted on the first rising edge after ap_rst is deasserted.

Verification (DW=32, AW=5)
REQ-022 Scenario 1: mode=00, L=24, a[i]=i, b[i]=100 -> y[i]=100+i for i=0..23, sat_cnt=0, ap_done exactly at T+26.
REQ-023 Scenario 2: mode=00, L=2, a=0x7FFFFFF0, b=0x20 -> y[0]=y[1]=0x7FFFFFFF, sat_cnt=2. Repeat with mode=11 -> y=0x80000010, sat_cnt=0.
REQ-024 Scenario 3: mode=01, L=1, a=0, b=0x80000000 -> y[0]=0x7FFFFFFF, sat_cnt=1. Mode=10 with the same operands -> y[0]=0x80000000, sat_cnt=0.
REQ-025 Scenario 4: L=0 -> ap_done at T+1, no ce/we activity. Then L=32 -> address 31 written last, no wrap to 0.
REQ-026 Scenario 5: ap_rst asserted at T+5 of an L=24 run -> outputs zero within the same cycle, no writes thereafter, no ap_done. A new start after reset completes normally.
REQ-027 Scenario 6: ap_start held high through RUN -> exactly one run; the next start is accepted only in IDLE, one cycle after ap_done.
